// File: rtl/mod_exp_stream.sv
// Streaming modular exponentiation m = c^d mod n (odd n) using one bit-serial
// radix-2 Montgomery multiplier and left-to-right square-and-multiply.
`ifndef CONFIG_DATA_WIDTH
`define CONFIG_DATA_WIDTH 8
`endif

module mod_exp_stream #(
  parameter int DATA_WIDTH = `CONFIG_DATA_WIDTH,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ce,
  input  logic                          abort,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         c,
  input  logic [DATA_WIDTH-1:0]         d,
  input  logic [$clog2(DATA_WIDTH)-1:0] t_sub_1,
  input  logic [DATA_WIDTH-1:0]         r2_mod_n,
  input  logic [DATA_WIDTH-1:0]         n,
  input  logic                          ct_mode,
  input  logic [TAG_WIDTH-1:0]          tag_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         m,
  output logic [TAG_WIDTH-1:0]          tag_out,
  output logic                          busy
);

  localparam int W  = DATA_WIDTH;
  localparam int IW = $clog2(DATA_WIDTH);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [W-1:0]  ONE     = {{(W-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] MM_LAST = CW'(W);

  typedef enum logic [2:0] {
    S_IDLE, S_TO_MONT_C, S_TO_MONT_1, S_SQR, S_MUL, S_FROM_MONT, S_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [W-1:0]         c_reg, d_reg, r2_reg, n_reg, p_reg, a_reg, m_reg;
  logic                 ct_reg, out_valid_reg;
  logic [TAG_WIDTH-1:0] tag_reg, tag_out_reg;
  logic [IW-1:0]        idx_reg;
  logic [W+1:0]         s_reg;
  logic [CW-1:0]        cnt_reg;

  logic [W-1:0] op_a, op_b, mm_res;
  logic [W+1:0] n_ext, mm_sum, mm_odd, mm_step;
  logic         a_bit, d_bit, do_mul, idx_zero, mm_last, accept, aborting;

  assign in_ready  = (state_reg == S_IDLE) & ~out_valid_reg;
  assign busy      = (state_reg != S_IDLE);
  assign out_valid = out_valid_reg;
  assign m         = m_reg;
  assign tag_out   = tag_out_reg;

  assign accept   = in_valid & in_ready;
  assign aborting = abort & (state_reg != S_IDLE);
  assign mm_last  = (cnt_reg == MM_LAST);
  assign idx_zero = (idx_reg == '0);
  assign d_bit    = |(d_reg & (ONE << idx_reg));
  assign do_mul   = d_bit | ct_reg;

  // Multiplier operands depend only on the phase; A and P change only at MM end.
  always_comb begin
    op_a = a_reg;
    op_b = a_reg;
    case (state_reg)
      S_TO_MONT_C: begin op_a = c_reg; op_b = r2_reg; end
      S_TO_MONT_1: begin op_a = ONE;   op_b = r2_reg; end
      S_MUL:       op_b = p_reg;
      S_FROM_MONT: op_b = ONE;
      default:     ;
    endcase
  end

  assign n_ext   = {2'b00, n_reg};
  assign a_bit   = |(op_a & (ONE << cnt_reg));
  assign mm_sum  = s_reg + (a_bit ? {2'b00, op_b} : '0);
  assign mm_odd  = mm_sum + (mm_sum[0] ? n_ext : '0);
  assign mm_step = mm_odd >> 1;
  assign mm_res  = (s_reg >= n_ext) ? W'(s_reg - n_ext) : W'(s_reg);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:      if (accept) state_next = S_TO_MONT_C;
      S_TO_MONT_C: if (mm_last) state_next = S_TO_MONT_1;
      S_TO_MONT_1: if (mm_last) state_next = S_SQR;
      S_SQR:
        if (mm_last) begin
          if (do_mul)        state_next = S_MUL;
          else if (idx_zero) state_next = S_FROM_MONT;
          else               state_next = S_SQR;
        end
      S_MUL:       if (mm_last) state_next = idx_zero ? S_FROM_MONT : S_SQR;
      S_FROM_MONT: if (mm_last) state_next = S_DONE;
      S_DONE:      state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
    if (aborting) state_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      c_reg         <= '0;
      d_reg         <= '0;
      r2_reg        <= '0;
      n_reg         <= '0;
      p_reg         <= '0;
      a_reg         <= '0;
      m_reg         <= '0;
      ct_reg        <= 1'b0;
      tag_reg       <= '0;
      tag_out_reg   <= '0;
      idx_reg       <= '0;
      s_reg         <= '0;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else if (ce) begin
      state_reg <= state_next;
      if (out_valid_reg && out_ready) out_valid_reg <= 1'b0;
      if (aborting) begin
        cnt_reg <= '0;
        s_reg   <= '0;
      end else begin
        case (state_reg)
          S_IDLE:
            if (accept) begin
              c_reg   <= c;
              d_reg   <= d;
              idx_reg <= t_sub_1;
              r2_reg  <= r2_mod_n;
              n_reg   <= n;
              ct_reg  <= ct_mode;
              tag_reg <= tag_in;
              cnt_reg <= '0;
              s_reg   <= '0;
            end
          S_DONE: begin
            m_reg         <= a_reg;
            tag_out_reg   <= tag_reg;
            out_valid_reg <= 1'b1;
          end
          default:
            if (mm_last) begin
              cnt_reg <= '0;
              s_reg   <= '0;
              case (state_reg)
                S_TO_MONT_C: p_reg <= mm_res;
                S_SQR: begin
                  a_reg <= mm_res;
                  if (!do_mul && !idx_zero) idx_reg <= idx_reg - IW'(1);
                end
                // In constant-time mode the product is computed but dropped on zero bits.
                S_MUL: begin
                  if (d_bit) a_reg <= mm_res;
                  if (!idx_zero) idx_reg <= idx_reg - IW'(1);
                end
                default: a_reg <= mm_res;
              endcase
            end else begin
              cnt_reg <= cnt_reg + CW'(1);
              s_reg   <= mm_step;
            end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mod_exp_stream.sv
// Self-checking bench for mod_exp_stream at W=8: directed table, corner-case
// sequences and random jobs against a plain-arithmetic exponentiation model.
module tb_mod_exp_stream;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst, ce, abort, in_valid, in_ready, ct_mode, out_valid, out_ready, busy;
  logic [7:0] c, d, r2_mod_n, n, m;
  logic [2:0] t_sub_1;
  logic [3:0] tag_in, tag_out;

  int total = 0;
  int bad   = 0;

  mod_exp_stream #(.DATA_WIDTH(W), .TAG_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .ce(ce), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready),
    .c(c), .d(d), .t_sub_1(t_sub_1), .r2_mod_n(r2_mod_n), .n(n),
    .ct_mode(ct_mode), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .m(m), .tag_out(tag_out), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] c;
    logic [7:0] d;
    logic [2:0] t;
    logic [7:0] n;
    logic       ct;
    logic [3:0] tag;
    logic [7:0] exp_m;
    int         exp_lat;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain repeated multiplication over d[t:0].
  function automatic longint model_m(input int cv, input int dv, input int t, input int nv);
    longint r = 1 % nv;
    int de = dv & ((2 << t) - 1);
    for (int i = 0; i < de; i++) r = (r * cv) % nv;
    return r;
  endfunction

  function automatic int model_lat(input int dv, input int t, input bit ct);
    int pc = 0;
    for (int i = 0; i <= t; i++) pc += (dv >> i) & 1;
    return (W + 1) * (3 + (t + 1) + (ct ? t + 1 : pc)) + 1;
  endfunction

  // Offers a job and returns one tick after the accepting edge; inputs are then scrambled.
  task automatic start_job(input int cv, input int dv, input int t, input int nv,
                           input bit ct, input int tg);
    int guard = 0;
    c = cv[7:0]; d = dv[7:0]; t_sub_1 = t[2:0]; n = nv[7:0];
    r2_mod_n = 8'((65536 % nv)); ct_mode = ct; tag_in = tg[3:0];
    in_valid = 1'b1;
    while (!(in_ready && ce) && guard < 200) begin tick(); guard++; end
    if (guard >= 200) chk("accept_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
    c = 8'($urandom); d = 8'($urandom); n = 8'($urandom); r2_mod_n = 8'($urandom);
    t_sub_1 = 3'($urandom); tag_in = 4'($urandom); ct_mode = 1'($urandom);
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 3000) begin tick(); lat++; end
    if (lat >= 3000) chk("result_timeout", 0, 1);
  endtask

  task automatic run_job(input string name, input int cv, input int dv, input int t,
                         input int nv, input bit ct, input int tg, input int exp_m,
                         input int exp_lat);
    int lat;
    start_job(cv, dv, t, nv, ct, tg);
    wait_result(lat);
    chk({name, "_m"}, m, exp_m);
    chk({name, "_tag"}, tag_out, tg & 15);
    chk({name, "_lat"}, lat, exp_lat);
    $display("job %s c=%0d d=%0d t=%0d n=%0d ct=%0d -> m=%0d tag=%0h lat=%0d",
             name, cv, dv, t, nv, ct, m, tag_out, lat);
    tick();
  endtask

  initial begin
    int lat, pre;
    logic [7:0] hold_m;
    logic [3:0] hold_tag;
    bit seen;

    tbl[0] = '{c:5,   d:3, t:1, n:187, ct:0, tag:4'hA, exp_m:125, exp_lat:64};
    tbl[1] = '{c:5,   d:2, t:1, n:187, ct:0, tag:4'hB, exp_m:25,  exp_lat:55};
    tbl[2] = '{c:5,   d:2, t:1, n:187, ct:1, tag:4'hC, exp_m:25,  exp_lat:64};
    tbl[3] = '{c:254, d:2, t:1, n:255, ct:0, tag:4'h1, exp_m:1,   exp_lat:55};
    tbl[4] = '{c:0,   d:5, t:2, n:255, ct:0, tag:4'h2, exp_m:0,   exp_lat:73};
    tbl[5] = '{c:7,   d:1, t:0, n:255, ct:0, tag:4'h3, exp_m:7,   exp_lat:46};

    rst = 1'b1; ce = 1'b1; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    c = '0; d = '0; t_sub_1 = '0; r2_mod_n = '0; n = '0; ct_mode = 1'b0; tag_in = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_m", m, 0);
    chk("rst_tag", tag_out, 0);

    for (int i = 0; i < 6; i++)
      run_job($sformatf("tbl%0d", i), tbl[i].c, tbl[i].d, tbl[i].t, tbl[i].n,
              tbl[i].ct, tbl[i].tag, tbl[i].exp_m, tbl[i].exp_lat);

    // Backpressure: result must hold and no new job may be taken.
    out_ready = 1'b0;
    start_job(5, 3, 1, 187, 0, 5);
    wait_result(lat);
    chk("bp_lat", lat, 64);
    hold_m = m; hold_tag = tag_out;
    c = 8'd9; d = 8'd7; t_sub_1 = 3'd2; n = 8'd187; r2_mod_n = 8'd86; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_m", m, 125);
      chk("bp_tag", tag_out, 5);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_busy", busy, 0);
    end
    $display("backpressure m=%0d tag=%0h held", hold_m, hold_tag);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ready", in_ready, 1);
    tick();

    // Abort mid-job, then a clean job.
    start_job(5, 3, 1, 187, 0, 6);
    for (int i = 0; i < 19; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    chk("abort_no_result", seen, 0);
    $display("abort issued, no result observed=%0d", !seen);
    run_job("post_abort", 5, 3, 1, 187, 0, 7, 125, 64);

    // Reset in the middle of a job.
    start_job(5, 3, 1, 187, 1, 8);
    for (int i = 0; i < 30; i++) tick();
    rst = 1'b1; abort = 1'b1;
    tick();
    rst = 1'b0; abort = 1'b0;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_m", m, 0);
    chk("midrst_tag", tag_out, 0);
    $display("mid-job reset applied");

    // Clock enable low for 5 cycles stretches latency by exactly 5.
    start_job(5, 3, 1, 187, 0, 9);
    pre = 0;
    for (int i = 0; i < 20; i++) begin tick(); pre++; end
    ce = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(); pre++; end
    ce = 1'b1;
    wait_result(lat);
    chk("ce_m", m, 125);
    chk("ce_tag", tag_out, 9);
    chk("ce_lat", pre + lat, 69);
    $display("ce stall job m=%0d lat=%0d", m, pre + lat);
    tick();

    // Random jobs against the arithmetic model.
    for (int k = 0; k < 40; k++) begin
      int nv, cv, t, dv, tg;
      bit ct;
      nv = 2 * $urandom_range(127, 1) + 1;
      cv = $urandom_range(nv - 1, 0);
      t  = $urandom_range(7, 0);
      dv = (1 << t) | ($urandom_range(255, 0) & ((1 << t) - 1));
      if ($urandom_range(3, 0) == 0) dv = dv | ($urandom_range(255, 0) & ~((2 << t) - 1) & 255);
      ct = 1'($urandom_range(1, 0));
      tg = $urandom_range(15, 0);
      run_job($sformatf("rnd%0d", k), cv, dv, t, nv, ct, tg,
              int'(model_m(cv, dv, t, nv)), model_lat(dv, t, ct));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mod_exp_stream.md
Name: mod_exp_stream

Overview:
- Next-generation modular exponentiation engine computing m = (c ^ d) mod n for odd n, with c < n and d > 0.
- Single internal bit-serial radix-2 Montgomery multiplier; left-to-right square-and-multiply.
- Valid/ready streaming handshake on input and output, with a pass-through job tag, abort, and a selectable constant-time mode.
- Sits at the same level as the existing exponentiation block and is intended as its drop-in streaming successor in the RSA datapath.

Parameters:
- DATA_WIDTH, `CONFIG_DATA_WIDTH, operand width W of c, d, n, r2_mod_n and m.
- TAG_WIDTH, 4, width of the job tag carried from input to output.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- ce  input  1  clock enable; when low, all state holds.
- abort  input  1  cancel the job in flight.
- in_valid  input  1  job offered.
- in_ready  output  1  job accepted when in_valid & in_ready are high at a clk edge with ce high.
- c  input  W  base, c < n.
- d  input  W  exponent, d > 0.
- t_sub_1  input  clog2(W)  index of the most significant set bit of d.
- r2_mod_n  input  W  (2^(2W)) mod n.
- n  input  W  modulus, odd.
- ct_mode  input  1  1 = always multiply (constant time); 0 = multiply only on set bits of d.
- tag_in  input  TAG_WIDTH  job tag.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer ready.
- m  output  W  result.
- tag_out  output  TAG_WIDTH  tag of the job that produced m.
- busy  output  1  job in flight.

Behaviour:
- Reset (synchronous, rst high at a clk edge, regardless of ce):
  - in_ready = 1, out_valid = 0, busy = 0, m = 0, tag_out = 0.
  - FSM returns to IDLE; all internal registers are cleared.
- ce low: every register holds; handshakes do not complete.
- in_ready = (state == IDLE) & ~out_valid. On accept, register c, d, t_sub_1, r2_mod_n, n, ct_mode and tag_in. busy rises on the next edge.
- MM(a, b) = a * b * 2^-W mod n, always returning a value < n:
  - Accumulator S is W+2 bits, cleared at MM start.
  - W iterations, one per cycle, over bits a_i, LSB first: S = S + a_i * b; if S is odd, S = S + n; S = S >> 1.
  - One further cycle: if S >= n, then S = S - n.
  - Each MM occupies exactly W+1 cycles. Consecutive MMs run back-to-back with no gap.
- FSM states: IDLE -> TO_MONT_C (P = MM(c, r2)) -> TO_MONT_1 (A = MM(1, r2)) -> loop over i = t_sub_1 down to 0 -> FROM_MONT (m = MM(A, 1)) -> DONE -> IDLE.
- Loop body for each bit i:
  - SQR: A = MM(A, A).
  - MUL, executed if d[i] | ct_mode: T = MM(A, P). A = T only if d[i] = 1; in ct_mode with d[i] = 0 the result is discarded.
  - Bit pointer decrements after MUL, or after SQR when MUL is skipped. The loop exits after bit 0.
- Latency: with the accept at edge E0, out_valid rises at edge E0 + L, where L = (W+1) * (3 + (t_sub_1+1) + M) + 1.
  - M = popcount(d[t_sub_1:0]) when ct_mode = 0; M = t_sub_1 + 1 when ct_mode = 1.
- DONE state: load m and tag_out, set out_valid, clear busy.
  - out_valid holds, with m and tag_out stable, until out_valid & out_ready at an edge; it clears on that edge.
  - in_ready rises the same edge out_valid clears.
- abort high at an edge while busy: FSM goes to IDLE, busy = 0, and no result is produced. abort in IDLE, or while out_valid is pending, has no effect. Simultaneous rst and abort: rst wins.
- Operand bits of d above t_sub_1 are ignored. Inputs with even n, c >= n or d = 0 give an undefined m but must not hang the FSM.
- Input registers are not touched while busy, so input values change freely during a job.

Test Plan:
- W=8, n=187, r2=86, c=5, d=3, t_sub_1=1, ct_mode=0, tag=0xA, out_ready=1 -> m=125, tag_out=0xA, out_valid exactly 64 cycles after accept.
- Same job with d=2: ct_mode=0 -> m=25 at 55 cycles; ct_mode=1 -> m=25 at 64 cycles.
- W=8, n=255, r2=1, c=254, d=2, t_sub_1=1 -> m=1. Also c=0, d=5 -> m=0; c=7, d=1, t_sub_1=0 -> m=7.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> m and tag_out stay stable, in_ready=0 and a new in_valid is not accepted. Raise out_ready -> out_valid drops and in_ready rises on the same edge.
- Abort 20 cycles into a job -> busy=0 and in_ready=1 next cycle, no out_valid. A following job c=5, d=3, n=187 -> m=125 with correct latency.
- rst asserted mid-job, and separately with ce=0 for 5 cycles mid-job -> reset values restored / latency stretched by exactly 5 cycles with the correct m.
